// File: rtl/myo_spi_responder.sv
// SPI mode-0 responder standing in for one myocontrol motor board.
// SPI pins are oversampled in the system clock domain; nothing runs on sck.
module myo_spi_responder #(
    parameter int FRAME_WORDS = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              sck,
    input  logic                              ss_n,
    input  logic                              mosi,
    output logic                              miso,
    output logic                              miso_oe,
    input  logic [16*FRAME_WORDS-1:0]         tx_frame,
    output logic                              tx_latched,
    output logic [15:0]                       rx_word,
    output logic [$clog2(FRAME_WORDS+1)-1:0]  rx_index,
    output logic                              rx_valid,
    output logic                              frame_done,
    output logic                              frame_error
);

    localparam int SW  = 16 * FRAME_WORDS;
    localparam int IW  = $clog2(FRAME_WORDS + 1);
    localparam int WCW = $clog2(FRAME_WORDS + 2);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;

    logic sck_s;
    logic ss_s;
    logic mosi_s;
    logic sck_d;
    logic ss_d;

    logic sck_rise;
    logic sck_fall;
    logic ss_rise;
    logic ss_fall;
    logic mosi_q;

    state_t           state;
    logic             armed;
    logic [3:0]       bit_cnt;
    logic [WCW-1:0]   word_cnt;
    logic [15:0]      rx_shift;
    logic [SW-1:0]    shadow;
    logic [SW-1:0]    tx_stream;

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // Reorder so word 0 sits at the top: the frame then streams out MSB first by shifting left.
    always_comb begin
        tx_stream = '0;
        for (int k = 0; k < FRAME_WORDS; k++) begin
            tx_stream[16*(FRAME_WORDS-1-k) +: 16] = tx_frame[16*k +: 16];
        end
    end

    // Synchronisers and registered edge pulses; mosi_q stays aligned with sck_rise.
    always_ff @(posedge clock) begin
        if (reset) begin
            sck_sync  <= '0;
            ss_sync   <= '0;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
            ss_d      <= 1'b0;
            sck_rise  <= 1'b0;
            sck_fall  <= 1'b0;
            ss_rise   <= 1'b0;
            ss_fall   <= 1'b0;
            mosi_q    <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sck_d     <= sck_s;
            ss_d      <= ss_s;
            sck_rise  <= sck_s & ~sck_d;
            sck_fall  <= ~sck_s & sck_d;
            ss_rise   <= ss_s & ~ss_d;
            ss_fall   <= ~ss_s & ss_d;
            mosi_q    <= mosi_s;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            armed       <= 1'b0;
            bit_cnt     <= '0;
            word_cnt    <= '0;
            rx_shift    <= '0;
            shadow      <= '0;
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
            tx_latched  <= 1'b0;
            rx_word     <= '0;
            rx_index    <= '0;
            rx_valid    <= 1'b0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            tx_latched  <= 1'b0;
            rx_valid    <= 1'b0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (ss_s) begin
                        armed <= 1'b1;
                    end
                    if (ss_fall && armed) begin
                        state      <= ACTIVE;
                        armed      <= 1'b0;
                        shadow     <= tx_stream;
                        tx_latched <= 1'b1;
                        bit_cnt    <= '0;
                        word_cnt   <= '0;
                        rx_shift   <= '0;
                        miso_oe    <= 1'b1;
                        miso       <= tx_stream[SW-1];
                    end
                end
                ACTIVE: begin
                    if (ss_rise) begin
                        state   <= IDLE;
                        miso_oe <= 1'b0;
                        miso    <= 1'b0;
                        if (word_cnt == WCW'(FRAME_WORDS) && bit_cnt == 4'd0) begin
                            frame_done <= 1'b1;
                        end else begin
                            frame_error <= 1'b1;
                        end
                    end else if (sck_rise) begin
                        rx_shift <= {rx_shift[14:0], mosi_q};
                        shadow   <= {shadow[SW-2:0], 1'b0};
                        if (bit_cnt == 4'd15) begin
                            bit_cnt  <= '0;
                            rx_word  <= {rx_shift[14:0], mosi_q};
                            rx_index <= word_cnt[IW-1:0];
                            rx_valid <= (word_cnt < WCW'(FRAME_WORDS));
                            if (word_cnt != WCW'(FRAME_WORDS + 1)) begin
                                word_cnt <= word_cnt + WCW'(1);
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else if (sck_fall) begin
                        // Zeros shift in behind the frame, so extra words read back as 0.
                        miso <= shadow[SW-1];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_myo_spi_responder.sv
// Randomised scoreboard bench for myo_spi_responder driven by a bit-banged SPI master.
// Expected words, indices and frame outcomes are queued per frame and popped by monitors.
module tb_myo_spi_responder;

    localparam int FW = 6;
    localparam int SS = 2;
    localparam int IW = $clog2(FW + 1);

    typedef struct packed {
        logic [15:0]   w;
        logic [IW-1:0] idx;
    } rx_exp_t;

    logic              clock = 1'b0;
    logic              reset;
    logic              sck;
    logic              ss_n;
    logic              mosi;
    logic              miso;
    logic              miso_oe;
    logic [16*FW-1:0]  tx_frame;
    logic              tx_latched;
    logic [15:0]       rx_word;
    logic [IW-1:0]     rx_index;
    logic              rx_valid;
    logic              frame_done;
    logic              frame_error;

    int vectors     = 0;
    int miscompares = 0;
    int lat_seen    = 0;
    int lat_exp     = 0;
    bit miso_chk    = 1'b1;

    rx_exp_t     rx_q[$];
    logic [15:0] miso_q[$];
    bit          end_q[$];
    logic [15:0] mw[9];

    myo_spi_responder #(
        .FRAME_WORDS(FW),
        .SYNC_STAGES(SS)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .sck        (sck),
        .ss_n       (ss_n),
        .mosi       (mosi),
        .miso       (miso),
        .miso_oe    (miso_oe),
        .tx_frame   (tx_frame),
        .tx_latched (tx_latched),
        .rx_word    (rx_word),
        .rx_index   (rx_index),
        .rx_valid   (rx_valid),
        .frame_done (frame_done),
        .frame_error(frame_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Output monitor: pops the scoreboard whenever the DUT pulses an output.
    always @(negedge clock) begin : mon
        rx_exp_t e;
        bit      d;
        if (tx_latched) lat_seen++;
        if (rx_valid) begin
            if (rx_q.size() == 0) begin
                check("rx_unexpected", 32'(rx_valid), 32'd0);
            end else begin
                e = rx_q.pop_front();
                check("rx_word", 32'(rx_word), 32'(e.w));
                check("rx_index", 32'(rx_index), 32'(e.idx));
            end
        end
        if (frame_done || frame_error) begin
            if (end_q.size() == 0) begin
                check("end_unexpected", 32'({frame_done, frame_error}), 32'd0);
            end else begin
                d = end_q.pop_front();
                check("frame_end", 32'({frame_done, frame_error}),
                      d ? 32'd2 : 32'd1);
            end
        end
    end

    // miso monitor: samples as a mode-0 master would, on sck rising edges.
    logic [15:0] cap;
    int          ncap = 0;
    always @(posedge sck or posedge ss_n) begin
        if (ss_n) begin
            ncap = 0;
        end else if (miso_chk) begin
            cap = {cap[14:0], miso};
            ncap++;
            if (ncap == 16) begin
                ncap = 0;
                check("miso_oe_sel", 32'(miso_oe), 32'd1);
                if (miso_q.size() == 0)
                    check("miso_unexpected", 32'(cap), 32'hDEAD);
                else
                    check("miso_word", 32'(cap), 32'(miso_q.pop_front()));
            end
        end
    end

    task automatic rand_tx();
        for (int k = 0; k < FW; k++) tx_frame[16*k +: 16] = 16'($urandom);
    endtask

    task automatic send_bits(input int w, input int nb);
        for (int b = 0; b < nb; b++) begin
            sck  = 1'b0;
            mosi = mw[w][15-b];
            tick(5);
            sck = 1'b1;
            tick(5);
        end
    endtask

    // One frame of nfull whole words plus npart bits; the model is the frame rules.
    task automatic run_frame(input int nfull, input int npart,
                             input bit chg, input int gap);
        rx_exp_t e;
        for (int i = 0; i < nfull; i++) begin
            if (i < FW) begin
                e.w   = mw[i];
                e.idx = IW'(i);
                rx_q.push_back(e);
                miso_q.push_back(tx_frame[16*i +: 16]);
            end else begin
                miso_q.push_back(16'h0000);
            end
        end
        end_q.push_back(nfull == FW && npart == 0);
        lat_exp++;
        ss_n = 1'b0;
        tick(6);
        for (int w = 0; w < nfull; w++) begin
            send_bits(w, 16);
            if (chg && w == 1) rand_tx();
        end
        if (npart > 0) send_bits(nfull, npart);
        sck = 1'b0;
        tick(5);
        ss_n = 1'b1;
        tick(gap);
        if (gap >= 8) begin
            check("miso_oe_idle", 32'(miso_oe), 32'd0);
            check("miso_idle", 32'(miso), 32'd0);
        end
    endtask

    initial begin
        reset    = 1'b1;
        sck      = 1'b0;
        ss_n     = 1'b1;
        mosi     = 1'b0;
        tx_frame = '0;
        tick(3);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_miso_oe", 32'(miso_oe), 32'd0);
        check("rst_rx_word", 32'(rx_word), 32'd0);
        check("rst_rx_index", 32'(rx_index), 32'd0);
        check("rst_pulses", 32'({tx_latched, rx_valid, frame_done, frame_error}), 32'd0);
        reset = 1'b0;
        tick(10);

        // Known pattern frame.
        for (int k = 0; k < FW; k++) tx_frame[16*k +: 16] = 16'h1111 * 16'(k + 1);
        for (int i = 0; i < 9; i++) mw[i] = 16'hA001 + 16'(i);
        run_frame(FW, 0, 1'b0, 12);

        // tx_frame altered mid-frame; miso must keep the latched words.
        rand_tx();
        for (int i = 0; i < 9; i++) mw[i] = 16'($urandom);
        run_frame(FW, 0, 1'b1, 12);

        // Short frame: 3 words + 5 bits.
        rand_tx();
        run_frame(3, 5, 1'b0, 12);

        // Long frame: 8 words.
        rand_tx();
        for (int i = 0; i < 9; i++) mw[i] = 16'($urandom);
        run_frame(8, 0, 1'b0, 12);

        // Reset mid-word with ss_n held low: nothing may come out afterwards.
        rand_tx();
        miso_chk = 1'b0;
        lat_exp++;
        ss_n = 1'b0;
        tick(6);
        send_bits(0, 5);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        send_bits(1, 16);
        check("post_rst_miso_oe", 32'(miso_oe), 32'd0);
        send_bits(2, 16);
        check("post_rst_miso", 32'(miso), 32'd0);
        sck = 1'b0;
        tick(5);
        ss_n = 1'b1;
        tick(12);
        miso_chk = 1'b1;
        rand_tx();
        run_frame(FW, 0, 1'b0, 12);

        // Back-to-back frames, ss_n high for 4 clocks between them.
        rand_tx();
        run_frame(FW, 0, 1'b0, 4);
        rand_tx();
        for (int i = 0; i < 9; i++) mw[i] = 16'($urandom);
        run_frame(FW, 0, 1'b0, 12);

        // Random frame lengths.
        for (int r = 0; r < 8; r++) begin
            int nf;
            int np;
            rand_tx();
            for (int i = 0; i < 9; i++) mw[i] = 16'($urandom);
            nf = int'($urandom_range(0, 8));
            np = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 15)) : 0;
            run_frame(nf, np, $urandom_range(0, 1) == 1, 12);
        end

        tick(40);
        check("rx_q_drained", 32'(rx_q.size()), 32'd0);
        check("miso_q_drained", 32'(miso_q.size()), 32'd0);
        check("end_q_drained", 32'(end_q.size()), 32'd0);
        check("tx_latched_count", 32'(lat_seen), 32'(lat_exp));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
